mult_share_arbiter: RTL and testbench

- Shares one combinational booth_multiplier instance between two requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel; grants alternate round-robin.
- Operands and product are registered around the multiplier, so its combinational path is isolated.
- Only one operation is in flight at a time. Sits between client datapaths and the signed multiplier.

---
 rtl/mult_share_pkg.sv | 17 +
 rtl/booth_multiplier.sv | 30 +++
 rtl/mult_share_arbiter.sv | 157 +++++++++++++++
 tb/tb_mult_share_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
// Holds the FSM encoding, requester IDs and the grant-history reset value.
package mult_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   // Last grant resets to requester 1 so requester 0 wins the first contention
   localparam logic LAST_GRANT_RST = REQ1;

endpackage

// File: rtl/booth_multiplier.sv
// Combinational radix-2 Booth multiplier: signed N x N -> 2N product.
// Inputs are two's complement; the full-width result never saturates.
module booth_multiplier #(
   parameter int N = 4
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] p
);

   logic [2*N-1:0] a_ext_s;
   logic [N:0]     b_ext_s;
   logic [2*N-1:0] acc_s;

   // Recode each multiplier bit pair {b[i], b[i-1]} into add/subtract/skip
   always_comb begin
      a_ext_s = {{N{a[N-1]}}, a};
      b_ext_s = {b, 1'b0};
      acc_s   = '0;
      for (int i = 0; i < N; i++) begin
         case (b_ext_s[i +: 2])
            2'b01:   acc_s = acc_s + (a_ext_s << i);
            2'b10:   acc_s = acc_s - (a_ext_s << i);
            default: acc_s = acc_s;
         endcase
      end
      p = acc_s;
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier between two requesters.
// Operands and product are registered; one operation is in flight at a time.
module mult_share_arbiter
   import mult_share_pkg::*;
#(
   parameter int N     = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [N-1:0]     req0_a,
   input  logic [N-1:0]     req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [N-1:0]     req1_a,
   input  logic [N-1:0]     req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [2*N-1:0]   rsp_p,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   state_t           state_r;
   state_t           next_state_s;
   logic             owner_r;
   logic             last_grant_r;
   logic [N-1:0]     a_r;
   logic [N-1:0]     b_r;
   logic [2*N-1:0]   product_s;
   logic [2*N-1:0]   rsp_p_r;
   logic [CNT_W-1:0] op_count_r;
   logic             busy_r;
   logic             rsp0_valid_r;
   logic             rsp1_valid_r;
   logic             grant0_s;
   logic             grant1_s;
   logic             rsp_hs_s;

   booth_multiplier #(.N(N)) u_mult (
      .a (a_r),
      .b (b_r),
      .p (product_s)
   );

   // Arbitration is open only in IDLE; reset closes both readies immediately
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (rst_n && (state_r == IDLE)) begin
         grant0_s = req0_valid && (!req1_valid || (last_grant_r == REQ1));
         grant1_s = req1_valid && (!req0_valid || (last_grant_r == REQ0));
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   // Response handshake counts only on the owner's channel
   always_comb begin
      rsp_hs_s = 1'b0;
      if (state_r == RESP) begin
         rsp_hs_s = (owner_r == REQ0) ? rsp0_ready : rsp1_ready;
      end else begin
         rsp_hs_s = 1'b0;
      end
   end

   // Next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant0_s || grant1_s) begin
               next_state_s = EXEC;
            end else begin
               next_state_s = IDLE;
            end
         end
         EXEC: next_state_s = RESP;
         RESP: begin
            if (rsp_hs_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = RESP;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // State register and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         busy_r       <= 1'b0;
         rsp0_valid_r <= 1'b0;
         rsp1_valid_r <= 1'b0;
      end else begin
         state_r      <= next_state_s;
         busy_r       <= (next_state_s != IDLE);
         rsp0_valid_r <= (next_state_s == RESP) && (owner_r == REQ0);
         rsp1_valid_r <= (next_state_s == RESP) && (owner_r == REQ1);
      end
   end

   // Operand capture and grant history on request handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r          <= '0;
         b_r          <= '0;
         owner_r      <= REQ0;
         last_grant_r <= LAST_GRANT_RST;
      end else if (grant0_s) begin
         a_r          <= req0_a;
         b_r          <= req0_b;
         owner_r      <= REQ0;
         last_grant_r <= REQ0;
      end else if (grant1_s) begin
         a_r          <= req1_a;
         b_r          <= req1_b;
         owner_r      <= REQ1;
         last_grant_r <= REQ1;
      end
   end

   // Product capture at the end of EXEC; held until the next operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_p_r <= '0;
      end else if (state_r == EXEC) begin
         rsp_p_r <= product_s;
      end
   end

   // Completed-operation counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count_r <= '0;
      end else if (rsp_hs_s) begin
         op_count_r <= op_count_r + CNT_W'(1);
      end
   end

   assign req0_ready = grant0_s;
   assign req1_ready = grant1_s;
   assign rsp0_valid = rsp0_valid_r;
   assign rsp1_valid = rsp1_valid_r;
   assign rsp_p      = rsp_p_r;
   assign busy       = busy_r;
   assign op_count   = op_count_r;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter against a transaction-level model.
// A narrow counter lets the bench exercise op_count wrap-around in a short run.
module tb_mult_share_arbiter;

   localparam int N     = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [N-1:0]     req0_a, req0_b, req1_a, req1_b;
   logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [2*N-1:0]   rsp_p;
   logic             busy;
   logic [CNT_W-1:0] op_count;

   mult_share_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp_p      (rsp_p),
      .busy       (busy),
      .op_count   (op_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Requester-side state: pending operands held until accepted
   logic           pend [2];
   logic [N-1:0]   pa   [2];
   logic [N-1:0]   pb   [2];
   int             p_req [2];
   int             p_rsp [2];
   logic [2*N-1:0] q0[$];
   logic [2*N-1:0] q1[$];

   // Reference model: one operation at a time, counted in cycles since accept
   bit             m_busy;
   int             m_owner;
   int             m_age;
   int             m_last;
   int             m_count;
   logic [2*N-1:0] m_prod;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
      int r;
      r = int'($signed(a)) * int'($signed(b));
      return r[2*N-1:0];
   endfunction

   task automatic model_reset();
      m_busy  = 1'b0;
      m_owner = 0;
      m_age   = 0;
      m_last  = 1;
      m_count = 0;
      m_prod  = '0;
   endtask

   task automatic push0(input int a, input int b);
      q0.push_back({N'(a), N'(b)});
   endtask

   task automatic push1(input int a, input int b);
      q1.push_back({N'(a), N'(b)});
   endtask

   task automatic fetch(input int x);
      logic [2*N-1:0] v;
      if (!pend[x]) begin
         if (x == 0 && q0.size() > 0) begin
            v = q0.pop_front();
            pend[x] = 1'b1; pa[x] = v[2*N-1:N]; pb[x] = v[N-1:0];
         end else if (x == 1 && q1.size() > 0) begin
            v = q1.pop_front();
            pend[x] = 1'b1; pa[x] = v[2*N-1:N]; pb[x] = v[N-1:0];
         end else if ($urandom_range(99, 0) < p_req[x]) begin
            pend[x] = 1'b1;
            pa[x]   = N'($urandom_range((1 << N) - 1, 0));
            pb[x]   = N'($urandom_range((1 << N) - 1, 0));
         end
      end
   endtask

   // One clock cycle: drive at negedge, check, then advance the model at posedge
   task automatic step();
      logic e_r0, e_r1, e_v0, e_v1, hs;
      fetch(0);
      fetch(1);
      req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0];
      req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1];
      rsp0_ready = ($urandom_range(99, 0) < p_rsp[0]);
      rsp1_ready = ($urandom_range(99, 0) < p_rsp[1]);
      #1;
      if (!rst_n) model_reset();
      e_r0 = rst_n && !m_busy && pend[0] && (!pend[1] || m_last == 1);
      e_r1 = rst_n && !m_busy && pend[1] && (!pend[0] || m_last == 0);
      e_v0 = m_busy && m_age >= 1 && m_owner == 0;
      e_v1 = m_busy && m_age >= 1 && m_owner == 1;
      check_eq("req0_ready", req0_ready, e_r0);
      check_eq("req1_ready", req1_ready, e_r1);
      check_eq("rsp0_valid", rsp0_valid, e_v0);
      check_eq("rsp1_valid", rsp1_valid, e_v1);
      check_eq("busy", busy, m_busy);
      check_eq("op_count", op_count, m_count % (1 << CNT_W));
      if (e_v0 || e_v1) check_eq("rsp_p", rsp_p, m_prod);
      if (!rst_n) check_eq("rsp_p_reset", rsp_p, 0);
      hs = m_busy && m_age >= 1 && ((m_owner == 0) ? rsp0_ready : rsp1_ready);
      @(posedge clk);
      if (rst_n) begin
         if (m_busy) begin
            if (hs) begin
               m_busy = 1'b0;
               m_count++;
            end else begin
               m_age++;
            end
         end else if (e_r0) begin
            m_busy = 1'b1; m_owner = 0; m_age = 0; m_last = 0;
            m_prod = ref_mul(pa[0], pb[0]);
            pend[0] = 1'b0;
         end else if (e_r1) begin
            m_busy = 1'b1; m_owner = 1; m_age = 0; m_last = 1;
            m_prod = ref_mul(pa[1], pb[1]);
            pend[1] = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      pend[0] = 1'b0; pend[1] = 1'b0;
      pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0;
      p_req = '{0, 0};
      p_rsp = '{100, 100};
      model_reset();
      @(negedge clk);

      // Reset held with both requests pending, then single/first-grant behaviour
      push0(-3, 5);
      push1(4, 4);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (12) step();

      // Continuous contention with fixed operands
      for (int i = 0; i < 4; i++) begin
         push0(6, -3);
         push1(7, 3);
      end
      repeat (30) step();

      // Response backpressure on requester 1 while requester 0 waits
      push1(-2, -2);
      p_rsp = '{100, 0};
      step();
      push0(1, 1);
      repeat (7) step();
      p_rsp = '{100, 100};
      repeat (8) step();

      // Reset while the operation is in EXEC
      push0(3, 3);
      for (int i = 0; i < 10; i++) begin
         step();
         if (m_busy && m_age == 0) break;
      end
      check_eq("exec_reached", busy, 1);
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      push0(2, -5);
      repeat (8) step();

      // Arithmetic corners
      push0(-8, -8);
      push0(-8, 7);
      push0(0, -8);
      push0(7, 7);
      push1(-8, -8);
      push1(7, -8);
      repeat (30) step();

      // Long random traffic, enough handshakes to wrap op_count
      p_req = '{60, 60};
      p_rsp = '{70, 70};
      repeat (3000) step();

      // Drain: every pending request must be served
      p_req = '{0, 0};
      p_rsp = '{100, 100};
      repeat (12) step();
      check_eq("drain_pend0", pend[0], 0);
      check_eq("drain_pend1", pend[1], 0);
      check_eq("drain_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
